// File: rtl/axi_sram_slave_if.sv
// AXI3 bus bundle between the CPU master port and the SRAM responder.
// The slave modport is the responder's view. The master modport is the initiator's view.
interface axi_sram_slave_if;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 responder backed by a word-organised SRAM, used to run the core without the SoC memory controller.
// The read and write channels are independent FSMs. Each FSM allows one outstanding INCR or FIXED burst.
module axi_sram_slave #(
  parameter int unsigned ADDR_W = 12,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic            aclk,
  input  logic            rst,
  axi_sram_slave_if.slave axi
);

  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam logic [31:0] SPAN_MASK = (32'd1 << (ADDR_W + 2)) - 32'd1;
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [1:0]  RESP_SLV  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a & ~SPAN_MASK) == BASE;
  endfunction

  // FIXED repeats the start address. WRAP falls through to INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + (32'd1 << size);
  endfunction

  function automatic logic [ADDR_W-1:0] word_idx(input logic [31:0] a);
    return a[ADDR_W+1:2];
  endfunction

  logic [31:0] mem [DEPTH];

  w_state_t    w_state_q, w_state_d;
  logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [3:0]  bid_q, bid_d, awid_q, awid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [31:0] waddr_q, waddr_d;
  logic [3:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]  wsize_q, wsize_d;
  logic [1:0]  wburst_q, wburst_d;
  logic        werr_q, werr_d, wbad_q, wbad_d;
  logic        w_final, w_mis, mem_we;

  r_state_t    r_state_q, r_state_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [3:0]  rid_q, rid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d, raddr_q, raddr_d, r_next;
  logic [3:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]  rsize_q, rsize_d;
  logic [1:0]  rburst_q, rburst_d;
  logic        ar_err;

  assign w_final = (wcnt_q == wlen_q);
  assign w_mis   = (axi.wlast != w_final);
  assign r_next  = next_addr(raddr_q, rsize_q, rburst_q);
  assign ar_err  = !addr_ok(axi.araddr) || (axi.arsize > 3'd2);

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    awid_d    = awid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    wbad_d    = wbad_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (axi.awvalid && awready_q) begin
          awid_d    = axi.awid;
          waddr_d   = axi.awaddr;
          wlen_d    = axi.awlen;
          wsize_d   = axi.awsize;
          wburst_d  = axi.awburst;
          werr_d    = !addr_ok(axi.awaddr) || (axi.awsize > 3'd2);
          wbad_d    = 1'b0;
          wcnt_d    = 4'd0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (axi.wvalid && wready_q) begin
          mem_we  = !werr_q;
          waddr_d = next_addr(waddr_q, wsize_q, wburst_q);
          wcnt_d  = wcnt_q + 4'd1;
          wbad_d  = wbad_q | w_mis;
          // The beat count ends the burst. A misplaced wlast only affects the response.
          if (w_final) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = awid_q;
            bresp_d   = (werr_q || wbad_q || w_mis) ? RESP_SLV : RESP_OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (axi.bready && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    case (r_state_q)
      R_IDLE: begin
        if (axi.arvalid && arready_q) begin
          rid_d     = axi.arid;
          raddr_d   = axi.araddr;
          rlen_d    = axi.arlen;
          rsize_d   = axi.arsize;
          rburst_d  = axi.arburst;
          rcnt_d    = 4'd0;
          rresp_d   = ar_err ? RESP_SLV : RESP_OKAY;
          rdata_d   = ar_err ? 32'd0 : mem[word_idx(axi.araddr)];
          rvalid_d  = 1'b1;
          rlast_d   = (axi.arlen == 4'd0);
          arready_d = 1'b0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && axi.rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            // The next beat is fetched on the same edge, so rready held high gives one beat per cycle.
            raddr_d = r_next;
            rdata_d = (rresp_q != RESP_OKAY) ? 32'd0 : mem[word_idx(r_next)];
            rcnt_d  = rcnt_q + 4'd1;
            rlast_d = ((rcnt_q + 4'd1) == rlen_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= 4'd0;
      bresp_q   <= 2'd0;
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= 4'd0;
      rresp_q   <= 2'd0;
      rdata_q   <= 32'd0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge aclk) begin
    awid_q   <= awid_d;
    waddr_q  <= waddr_d;
    wlen_q   <= wlen_d;
    wsize_q  <= wsize_d;
    wburst_q <= wburst_d;
    wcnt_q   <= wcnt_d;
    werr_q   <= werr_d;
    wbad_q   <= wbad_d;
    raddr_q  <= raddr_d;
    rlen_q   <= rlen_d;
    rsize_q  <= rsize_d;
    rburst_q <= rburst_d;
    rcnt_q   <= rcnt_d;
  end

  // Reads sample the array before this edge's write, so a same-cycle collision returns the old word.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (axi.wstrb[i]) mem[word_idx(waddr_q)][8*i +: 8] <= axi.wdata[8*i +: 8];
      end
    end
  end

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bid     = bid_q;
  assign axi.bresp   = bresp_q;
  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rlast   = rlast_q;
  assign axi.rid     = rid_q;
  assign axi.rresp   = rresp_q;
  assign axi.rdata   = rdata_q;

  logic unused_ok;
  assign unused_ok = ^{axi.awlock, axi.awcache, axi.awprot, axi.arlock, axi.arcache,
                       axi.arprot, axi.wid};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave. Each read beat is checked against a queue of expected words.
// The queue is filled when the read is issued.
module tb_axi_sram_slave;
  logic aclk = 1'b0;
  logic rst;
  always #5 aclk = ~aclk;

  axi_sram_slave_if axi();

  axi_sram_slave #(.ADDR_W(12), .BASE(32'h0000_0000)) dut (
    .aclk(aclk),
    .rst (rst),
    .axi (axi.slave)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wdat[16];
  time         aw_t, ar_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [3:0] strb, input int last_beat,
                           input int bstall, output logic [1:0] resp, output logic [3:0] rbid);
    int n;
    axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = 3'd2;
    axi.awburst = burst; axi.awvalid = 1'b1;
    n = 0;
    while (axi.awready !== 1'b1 && n < 50) begin tick(); n++; end
    chk("aw_accept", 32'(n < 50), 32'd1);
    aw_t = $time;
    tick();
    axi.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      axi.wdata = wdat[i]; axi.wstrb = strb; axi.wlast = (i == last_beat); axi.wvalid = 1'b1;
      n = 0;
      while (axi.wready !== 1'b1 && n < 50) begin tick(); n++; end
      chk("w_accept", 32'(n < 50), 32'd1);
      tick();
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    for (int i = 0; i < bstall; i++) begin
      chk("b_hold_valid", 32'(axi.bvalid), 32'd1);
      chk("b_hold_awready", 32'(axi.awready), 32'd0);
      tick();
    end
    n = 0;
    while (axi.bvalid !== 1'b1 && n < 50) begin tick(); n++; end
    chk("b_valid", 32'(axi.bvalid), 32'd1);
    resp = axi.bresp; rbid = axi.bid;
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    chk("b_drop", 32'(axi.bvalid), 32'd0);
    chk("aw_ready_after_b", 32'(axi.awready), 32'd1);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input bit stall, input logic [1:0] eresp);
    int n;
    logic [31:0] e;
    axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = 3'd2;
    axi.arburst = burst; axi.arvalid = 1'b1;
    n = 0;
    while (axi.arready !== 1'b1 && n < 50) begin tick(); n++; end
    chk("ar_accept", 32'(n < 50), 32'd1);
    ar_t = $time;
    tick();
    axi.arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $error("FAIL sb_empty observed=%0d expected=nonzero", exp_q.size());
        e = 32'd0;
      end else begin
        e = exp_q.pop_front();
      end
      if (stall && i > 0) begin
        axi.rready = 1'b0;
        repeat (2) begin
          tick();
          chk("r_stall_valid", 32'(axi.rvalid), 32'd1);
          chk("r_stall_data", axi.rdata, e);
        end
      end
      axi.rready = 1'b1;
      chk("r_valid", 32'(axi.rvalid), 32'd1);
      chk("r_data", axi.rdata, e);
      chk("r_last", 32'(axi.rlast), 32'(i == int'(len)));
      chk("r_id", 32'(axi.rid), 32'(id));
      chk("r_resp", 32'(axi.rresp), 32'(eresp));
      tick();
    end
    axi.rready = 1'b0;
    chk("r_done_valid", 32'(axi.rvalid), 32'd0);
    chk("r_done_arready", 32'(axi.arready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] resp, resp2;
    logic [3:0] b_id;
    axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0; axi.awburst = 0;
    axi.awlock = 0; axi.awcache = 0; axi.awprot = 0; axi.awvalid = 0;
    axi.wid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.wvalid = 0; axi.bready = 0;
    axi.arid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0;
    axi.arlock = 0; axi.arcache = 0; axi.arprot = 0; axi.arvalid = 0; axi.rready = 0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_awready", 32'(axi.awready), 32'd1);
    chk("rst_arready", 32'(axi.arready), 32'd1);
    chk("rst_wready", 32'(axi.wready), 32'd0);
    chk("rst_bvalid", 32'(axi.bvalid), 32'd0);
    chk("rst_rvalid", 32'(axi.rvalid), 32'd0);
    chk("rst_rlast", 32'(axi.rlast), 32'd0);
    chk("rst_rdata", axi.rdata, 32'd0);

    // Preload the words used by later steps.
    wdat[0] = 32'h1234_5678;
    axi_write(4'h0, 32'h0, 4'd0, 2'b01, 4'hF, 0, 0, resp, b_id);
    chk("pre0_resp", 32'(resp), 32'd0);
    wdat[0] = 32'h1122_3344;
    axi_write(4'h0, 32'h10, 4'd0, 2'b01, 4'hF, 0, 0, resp, b_id);
    chk("pre10_resp", 32'(resp), 32'd0);
    for (int i = 0; i < 16; i++) wdat[i] = 32'hA000_0000 + 32'(i) * 32'h111;
    axi_write(4'h0, 32'h100, 4'd15, 2'b01, 4'hF, 15, 0, resp, b_id);
    chk("pre100_resp", 32'(resp), 32'd0);

    // Reset in the middle of an 8-beat read.
    axi.arid = 4'h1; axi.araddr = 32'h100; axi.arlen = 4'd7; axi.arsize = 3'd2;
    axi.arburst = 2'b01; axi.arvalid = 1'b1;
    tick();
    axi.arvalid = 1'b0; axi.rready = 1'b1;
    tick(); tick();
    chk("mid_rvalid", 32'(axi.rvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rvalid", 32'(axi.rvalid), 32'd0);
    chk("async_arready", 32'(axi.arready), 32'd1);
    chk("async_rlast", 32'(axi.rlast), 32'd0);
    @(posedge aclk); #1;
    rst = 1'b0; axi.rready = 1'b0;
    tick();
    chk("post_rst_arready", 32'(axi.arready), 32'd1);
    chk("post_rst_rvalid", 32'(axi.rvalid), 32'd0);

    // Partial-strobe single write, then read the merged word back.
    wdat[0] = 32'hDEAD_BEEF;
    axi_write(4'h5, 32'h10, 4'd0, 2'b01, 4'b0101, 0, 0, resp, b_id);
    chk("single_bresp", 32'(resp), 32'd0);
    chk("single_bid", 32'(b_id), 32'h5);
    exp_q.push_back(32'h11AD_33EF);
    axi_read(4'h2, 32'h10, 4'd0, 2'b01, 1'b0, 2'b00);

    // 16-beat INCR read at full rate.
    for (int i = 0; i < 16; i++) exp_q.push_back(32'hA000_0000 + 32'(i) * 32'h111);
    axi_read(4'h3, 32'h100, 4'd15, 2'b01, 1'b0, 2'b00);

    // Read with backpressure, then a write response held off by bready.
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA000_0000 + 32'(i) * 32'h111);
    axi_read(4'h4, 32'h100, 4'd3, 2'b01, 1'b1, 2'b00);
    wdat[0] = 32'h0000_CAFE;
    axi_write(4'h6, 32'h30, 4'd0, 2'b01, 4'hF, 0, 5, resp, b_id);
    chk("bstall_bresp", 32'(resp), 32'd0);
    chk("bstall_bid", 32'(b_id), 32'h6);

    // Out-of-range write aliases word 0, which must stay intact.
    wdat[0] = 32'hBADB_AD00;
    axi_write(4'h7, 32'h4000, 4'd0, 2'b01, 4'hF, 0, 0, resp, b_id);
    chk("oor_bresp", 32'(resp), 32'h2);
    chk("oor_bid", 32'(b_id), 32'h7);
    exp_q.push_back(32'h1234_5678);
    axi_read(4'h8, 32'h0, 4'd0, 2'b01, 1'b0, 2'b00);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    axi_read(4'h9, 32'h4000, 4'd1, 2'b01, 1'b0, 2'b10);

    // wlast on the second of four beats: all four beats are still consumed.
    for (int i = 0; i < 4; i++) wdat[i] = 32'h5000_0000 + 32'(i);
    axi_write(4'hA, 32'h200, 4'd3, 2'b01, 4'hF, 1, 0, resp, b_id);
    chk("wlast_bresp", 32'(resp), 32'h2);
    chk("wlast_bid", 32'(b_id), 32'hA);

    // FIXED write concurrent with an INCR read. Both address channels are accepted together.
    for (int i = 0; i < 4; i++) wdat[i] = 32'(i + 1);
    exp_q.push_back(32'hA000_0000);
    exp_q.push_back(32'hA000_0111);
    fork
      axi_write(4'hB, 32'h20, 4'd3, 2'b00, 4'hF, 3, 0, resp, b_id);
      axi_read(4'hC, 32'h100, 4'd1, 2'b01, 1'b0, 2'b00);
    join
    chk("fixed_bresp", 32'(resp), 32'd0);
    chk("aw_ar_same_cycle", aw_t[31:0], ar_t[31:0]);
    exp_q.push_back(32'd4);
    axi_read(4'hD, 32'h20, 4'd0, 2'b01, 1'b0, 2'b00);
    resp2 = 2'b00;
    chk("sb_drained", 32'(exp_q.size()), 32'(resp2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
AXI3 responder, the slave end of the CPU's 32-bit AXI master port. It answers the instruction-cache, data-cache and crossbar traffic with an internal word-organised SRAM, so the core can be simulated and tested without the SoC memory controller. Read and write channels run as independent state machines, each with one outstanding transaction. INCR and FIXED bursts of 1-16 beats are supported.

Parameters:
ADDR_W, 12, word-address width; capacity is 2^ADDR_W 32-bit words (16 KiB by default).
BASE, 32'h0000_0000, byte base address; must be aligned to 2^(ADDR_W+2).

Ports:
aclk  in  1  clock; all logic is on the rising edge.
rst  in  1  asynchronous, active-high reset.
awid/awaddr/awlen/awsize/awburst  in  4/32/4/3/2  write address channel; awlen+1 beats.
awlock/awcache/awprot  in  2/4/3  ignored.
awvalid  in 1; awready  out 1  write address handshake.
wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1  write data channel; wid is ignored.
wready  out  1  write data ready.
bid/bresp/bvalid  out  4/2/1  write response.
bready  in  1  write response ready.
arid/araddr/arlen/arsize/arburst  in  4/32/4/3/2  read address channel.
arlock/arcache/arprot  in  2/4/3  ignored.
arvalid  in 1; arready  out 1  read address handshake.
rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1  read data channel.
rready  in  1  read data ready.

Behaviour:
- Reset (asynchronous):
  - Both FSMs go to IDLE.
  - awready=1, arready=1; wready, bvalid, rvalid, rlast = 0; bid, rid, bresp, rresp, rdata = 0.
  - SRAM contents are not cleared.
  - Reset mid-burst abandons the burst with no response; writes already performed persist.
- Handshake: a transfer occurs on a cycle where valid && ready. Outputs are registered. valid is never withdrawn before its handshake, and payload is held stable while valid is asserted.
- Address decode: a transaction is in range if its start address satisfies (addr & ~(2^(ADDR_W+2)-1)) == BASE.
  - Out-of-range reads: every beat returns rresp=2'b10 (SLVERR) and rdata=0.
  - Out-of-range writes: data is discarded and bresp=SLVERR.
  - Word index = addr[ADDR_W+1:2].
- Burst address: INCR adds (1<<size) per beat, with 32-bit wrap-around. FIXED repeats the start address. WRAP (2'b10) is treated as INCR. Size > 3'b010 returns SLVERR, and the burst still completes its beat count.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On AW handshake, latch id, addr, len, size, burst and range status; go to W_DATA with awready=0 and wready=1.
  - W_DATA: on each W handshake, write bytes where wstrb[i]=1 (lane i = wdata[8i+7:8i]), advance the address and increment the beat counter.
  - When the counter reaches len, go to W_RESP: wready=0, bvalid=1, bid = latched id.
  - bresp=OKAY unless out of range, unsupported size, or a wlast mismatch (wlast=1 before the final beat, or 0 on it), in which case bresp=SLVERR. The beat count always governs termination.
  - W_RESP: on B handshake, bvalid=0, awready=1, return to W_IDLE. The earliest next AW is accepted the cycle after the B handshake.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On AR handshake, latch fields, load rdata from mem[start], set rvalid=1 and rlast=(arlen==0), arready=0. The first beat is visible the next cycle (1-cycle latency).
  - R_DATA: on an R handshake for a non-final beat, rdata is loaded from the next address the same edge and rvalid stays 1. With rready held high this gives one beat per cycle.
  - On an R handshake with rlast=1: rvalid=0, rlast=0, arready=1, return to R_IDLE.
  - With rready=0, rdata, rid, rresp and rlast hold.
- Read/write collision: a read of a word written in the same cycle returns the old value. Write-then-read ordering is the master's responsibility.
- The AW and AR channels are independent; simultaneous acceptance is allowed.

Test Plan:
1. Reset, then check awready=arready=1 and all valids 0. Assert rst during an 8-beat read; rvalid must drop asynchronously and arready=1 after release.
2. Single write: awaddr=0x10, awlen=0, awsize=2, wdata=0xDEADBEEF, wstrb=4'b0101, over a word holding 0x11223344 -> bresp=0, bid=awid, mem becomes 0x11AD33EF. A following read of 0x10 returns 0x11AD33EF with rlast=1.
3. INCR read, araddr=0x100, arlen=15, arid=4'h3, rready=1 throughout -> 16 consecutive beats, words 0x100..0x13C, rlast only on beat 16, rid=3, rresp=0.
4. Backpressure: 4-beat read with rready toggled 1,0,0,1,... -> rdata stable while stalled, no beat lost or duplicated. bready held 0 for 5 cycles -> bvalid held, awready stays 0.
5. Errors:
   - awaddr=BASE+0x4000 (out of range) -> bresp=2'b10, memory unchanged.
   - 4-beat write with wlast on beat 2 -> 4 beats consumed, bresp=2'b10.
6. FIXED 4-beat write to 0x20 with data 1,2,3,4 -> mem[0x20]=4. Concurrent AR/AW in the same cycle are both accepted.
